stim_sequencer: RTL and testbench
=================================

# stim_sequencer

Sequential stimulus generator that sits directly upstream of the 3-input/2-output combinational lab blocks (p, q, r in; x, y out). On a start pulse it walks the inputs through all 8 combinations in binary order (000 to 111), holds each for a programmable dwell, and samples the block's response at the end of each dwell. When the sweep finishes it reports the captured truth table and a pass/fail against an expected table. This replaces hand-written delay sequences with a synthesizable sweep.

## Interface
Parameters:
- DWELL, default 4: clock cycles each input vector is held; legal range 1..255.
- EXPECT, default 16'h0000: expected truth table, packed in the same layout as `table_out`.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- p  output  1  stimulus MSB (`vec[2]`).
- q  output  1  stimulus middle bit (`vec[1]`).
- r  output  1  stimulus LSB (`vec[0]`).
- x  input  1  response bit 0 from the downstream block.
- y  input  1  response bit 1 from the downstream block.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  16  captured truth table; `{y,x}` for vector i sits at `[2i+1:2i]`.
- pass  output  1  `table_out == EXPECT`; qualified by `done`.

## Operation
- The state machine has three states:
  - IDLE: `busy=0`. If `start=1`, go to DRIVE with `idx=0` and `cnt=DWELL-1`.
  - DRIVE: `busy=1` and `{p,q,r}=idx`. `cnt` decrements each cycle. When `cnt==0`:
    - sample `{y,x}` into `table_out[2*idx +: 2]`;
    - if `idx==7`, go to DONE;
    - otherwise increment `idx` and reload `cnt=DWELL-1`.
  - DONE: `done=1` and `busy=0` for exactly one cycle, then go to IDLE.
- `pass` is evaluated combinationally from `table_out`.
- In IDLE and DONE, `{p,q,r}=000`.
- `table_out` holds its value after DONE until the next sweep overwrites it entry by entry. It is not cleared at start.
- `start` is ignored in DRIVE and DONE; no queuing.
- `start` held high continuously gives back-to-back sweeps separated by one IDLE cycle.
- Reset values: state IDLE, `idx=0`, `cnt=0`, `p=q=r=0`, `busy=0`, `done=0`, `table_out=16'h0000`. `pass` is then `(EXPECT==0)`.
- Reset asserted mid-sweep aborts immediately: all outputs return to reset values on the same edge, with no `done` pulse.
- `idx` is 3 bits and `cnt` is 8 bits. `idx` never wraps inside a sweep, because the exit happens at 7.

## Timing
- Let edge 0 be the edge that samples `start=1` in IDLE.
- Vector i is driven on cycles `1+i*DWELL` through `(i+1)*DWELL`.
- Vector i is sampled at edge `(i+1)*DWELL`, i.e. the last cycle of its dwell. The downstream block therefore has DWELL-1 cycles to settle.
- `done` is high during cycle `8*DWELL+1`. With DWELL=4, that is cycle 33.
- `busy` is high during cycles 1 through `8*DWELL`.
- With DWELL=1, the input changes every cycle and each sample is taken at the end of that same cycle.
- Total sweep period, start to the next possible start: `8*DWELL+2` cycles.

## Structure
- Package `stim_pkg` holds:
  - the state enum `stim_state_t` (IDLE, DRIVE, DONE);
  - `N_IN=3`, `N_OUT=2`, `N_VEC=8`;
  - `TABLE_W=16`.
- One sub-module, `dwell_timer`, owns the down-counter. Its ports are load, enable and `zero` flag; width is derived from DWELL.
- Everything else lives in `stim_sequencer`: the FSM, `idx`, the capture register and the comparator.

## Test plan
- Full-adder DUT (`x=p^q^r`, `y=majority`), DWELL=4, EXPECT=16'hE994, start pulsed at cycle 0 → stimulus steps 000…111 every 4 cycles; `done` at cycle 33; `table_out=16'hE994`; `pass=1`.
- Same DUT with EXPECT=16'hE995 → `table_out=16'hE994`; `pass=0` when `done` pulses.
- DWELL=1, DUT `x=p`, `y=0` → `done` at cycle 9; `table_out=16'h5500`.
- `start` re-pulsed at cycles 5 and 20 during a DWELL=4 sweep → no restart; exactly one `done` at cycle 33.
- Reset asserted at cycle 14 → `p=q=r=0`, `busy=0`, `table_out=0` immediately; no `done` pulse. Start at cycle 20 → `done` at cycle 53.
- `start` held high continuously, DWELL=2 → `done` pulses at cycles 17 and 35; `busy` low only on the DONE and IDLE cycles between sweeps.

Source files
------------

// File: rtl/stim_sequencer_pkg.sv
// Shared types and sizes for the stimulus sequencer.
// Sized for the 3-input / 2-output combinational lab blocks it drives.
package stim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } stim_state_t;

    localparam int N_IN    = 3;
    localparam int N_OUT   = 2;
    localparam int N_VEC   = 8;
    localparam int TABLE_W = N_OUT * N_VEC;

endpackage

// File: rtl/stim_sequencer_dwell_timer.sv
// Down-counter that times how long each input vector is held.
// Loading sets it to DWELL-1; it then counts down to zero and stays there.
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic zero
);

    localparam int W = (DWELL < 2) ? 1 : $clog2(DWELL);
    localparam logic [W-1:0] RELOAD = W'(DWELL - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/stim_sequencer.sv
// Sweeps {p,q,r} through 000..111, holds each vector DWELL cycles, captures {y,x}
// at the end of each dwell and compares the captured truth table against EXPECT.
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int                   DWELL  = 4,
    parameter logic [TABLE_W-1:0]   EXPECT = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               p,
    output logic               q,
    output logic               r,
    input  logic               x,
    input  logic               y,
    output logic               busy,
    output logic               done,
    output logic [TABLE_W-1:0] table_out,
    output logic               pass
);

    stim_state_t        state;
    stim_state_t        next_state;
    logic [N_IN-1:0]    idx;
    logic [TABLE_W-1:0] table_q;
    logic               load;
    logic               enable;
    logic               zero;
    logic               capture;
    logic               last_vec;

    assign last_vec = (idx == N_IN'(N_VEC - 1));

    dwell_timer #(
        .DWELL(DWELL)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .enable(enable),
        .zero  (zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The timer reaching zero marks the last cycle of a dwell: sample, then advance or finish.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        enable     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = DRIVE;
                    load       = 1'b1;
                end
            end
            DRIVE: begin
                if (zero) begin
                    capture = 1'b1;
                    if (last_vec) begin
                        next_state = DONE;
                    end else begin
                        load = 1'b1;
                    end
                end else begin
                    enable = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if ((state == IDLE) && start) begin
            idx <= '0;
        end else if (capture && !last_vec) begin
            idx <= idx + 1'b1;
        end
    end

    // Entries are overwritten one at a time; the table is deliberately not cleared on start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            table_q <= '0;
        end else if (capture) begin
            table_q[N_OUT*idx +: N_OUT] <= {y, x};
        end
    end

    assign {p, q, r}  = (state == DRIVE) ? idx : '0;
    assign busy       = (state == DRIVE);
    assign done       = (state == DONE);
    assign table_out  = table_q;
    assign pass       = (table_q == EXPECT);

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer: four instances with different dwell/expect settings,
// each driving its own model of a downstream combinational block.
module tb_stim_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic start_ab, start_c, start_d;

    logic pa, qa, ra, xa, ya, busy_a, done_a, pass_a;
    logic pb, qb, rb, xb, yb, busy_b, done_b, pass_b;
    logic pc, qc, rc, xc, yc, busy_c, done_c, pass_c;
    logic pd, qd, rd, xd, yd, busy_d, done_d, pass_d;
    logic [15:0] table_a, table_b, table_c, table_d;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Downstream blocks: full adders for A/B, x=p for C, {y,x}={r,q} for D
    assign xa = pa ^ qa ^ ra;
    assign ya = (pa & qa) | (pa & ra) | (qa & ra);
    assign xb = pb ^ qb ^ rb;
    assign yb = (pb & qb) | (pb & rb) | (qb & rb);
    assign xc = pc;
    assign yc = 1'b0;
    assign xd = qd;
    assign yd = rd;

    stim_sequencer #(.DWELL(4), .EXPECT(16'hE994)) dut_a (
        .clk(clk), .reset(reset), .start(start_ab), .p(pa), .q(qa), .r(ra),
        .x(xa), .y(ya), .busy(busy_a), .done(done_a), .table_out(table_a), .pass(pass_a));

    stim_sequencer #(.DWELL(4), .EXPECT(16'hE995)) dut_b (
        .clk(clk), .reset(reset), .start(start_ab), .p(pb), .q(qb), .r(rb),
        .x(xb), .y(yb), .busy(busy_b), .done(done_b), .table_out(table_b), .pass(pass_b));

    stim_sequencer #(.DWELL(1), .EXPECT(16'h5500)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .p(pc), .q(qc), .r(rc),
        .x(xc), .y(yc), .busy(busy_c), .done(done_c), .table_out(table_c), .pass(pass_c));

    stim_sequencer #(.DWELL(2), .EXPECT(16'h0000)) dut_d (
        .clk(clk), .reset(reset), .start(start_d), .p(pd), .q(qd), .r(rd),
        .x(xd), .y(yd), .busy(busy_d), .done(done_d), .table_out(table_d), .pass(pass_d));

    task automatic test_reset;
        reset    = 1'b1;
        start_ab = 1'b0;
        start_c  = 1'b0;
        start_d  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if ({pa, qa, ra} !== 3'b000) begin bad++; $display("[TB] FAIL reset_pqr got=%b want=000", {pa, qa, ra}); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done_a); end
        total++; if (table_a !== 16'h0000) begin bad++; $display("[TB] FAIL reset_table got=%h want=0000", table_a); end
        total++; if (pass_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_pass_a got=%b want=0", pass_a); end
        total++; if (pass_d !== 1'b1) begin bad++; $display("[TB] FAIL reset_pass_d got=%b want=1", pass_d); end
        reset = 1'b0;
    endtask

    task automatic test_full_adder;
        logic [2:0] exp_vec;
        @(negedge clk);
        start_ab = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            start_ab = 1'b0;
            exp_vec = (c <= 32) ? 3'((c - 1) / 4) : 3'd0;
            total++; if ({pa, qa, ra} !== exp_vec) begin bad++; $display("[TB] FAIL fa_vec c=%0d got=%b want=%b", c, {pa, qa, ra}, exp_vec); end
            total++; if (busy_a !== (c <= 32)) begin bad++; $display("[TB] FAIL fa_busy c=%0d got=%b want=%b", c, busy_a, (c <= 32)); end
            total++; if (done_a !== (c == 33)) begin bad++; $display("[TB] FAIL fa_done c=%0d got=%b want=%b", c, done_a, (c == 33)); end
            if (c == 33) begin
                total++; if (table_a !== 16'hE994) begin bad++; $display("[TB] FAIL fa_table got=%h want=e994", table_a); end
                total++; if (pass_a !== 1'b1) begin bad++; $display("[TB] FAIL fa_pass got=%b want=1", pass_a); end
                total++; if (done_b !== 1'b1) begin bad++; $display("[TB] FAIL fb_done got=%b want=1", done_b); end
                total++; if (table_b !== 16'hE994) begin bad++; $display("[TB] FAIL fb_table got=%h want=e994", table_b); end
                total++; if (pass_b !== 1'b0) begin bad++; $display("[TB] FAIL fb_pass got=%b want=0", pass_b); end
            end
        end
    endtask

    task automatic test_restart_ignored;
        int n_done;
        n_done = 0;
        @(negedge clk);
        start_ab = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done_a === 1'b1) n_done++;
            total++; if (done_a !== (c == 33)) begin bad++; $display("[TB] FAIL rs_done c=%0d got=%b want=%b", c, done_a, (c == 33)); end
            if (c == 6 || c == 21) begin
                total++; if ({pa, qa, ra} !== 3'((c - 1) / 4)) begin bad++; $display("[TB] FAIL rs_vec c=%0d got=%b want=%b", c, {pa, qa, ra}, 3'((c - 1) / 4)); end
            end
            if (c == 33) begin
                total++; if (table_a !== 16'hE994) begin bad++; $display("[TB] FAIL rs_table got=%h want=e994", table_a); end
            end
            start_ab = (c == 5 || c == 20);
        end
        total++; if (n_done != 1) begin bad++; $display("[TB] FAIL rs_done_count got=%0d want=1", n_done); end
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        start_ab = 1'b1;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            total++; if (done_a !== (c == 53)) begin bad++; $display("[TB] FAIL mr_done c=%0d got=%b want=%b", c, done_a, (c == 53)); end
            if (c == 53) begin
                total++; if (table_a !== 16'hE994) begin bad++; $display("[TB] FAIL mr_table got=%h want=e994", table_a); end
                total++; if (pass_a !== 1'b1) begin bad++; $display("[TB] FAIL mr_pass got=%b want=1", pass_a); end
            end
            if (c == 14) begin
                reset = 1'b1;
                #1;
                total++; if ({pa, qa, ra} !== 3'b000) begin bad++; $display("[TB] FAIL mr_pqr got=%b want=000", {pa, qa, ra}); end
                total++; if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL mr_busy got=%b want=0", busy_a); end
                total++; if (table_a !== 16'h0000) begin bad++; $display("[TB] FAIL mr_table0 got=%h want=0000", table_a); end
            end
            if (c == 16) reset = 1'b0;
            start_ab = (c == 20);
        end
    endtask

    task automatic test_dwell_one;
        @(negedge clk);
        start_c = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_c = 1'b0;
            total++; if ({pc, qc, rc} !== ((c <= 8) ? 3'(c - 1) : 3'd0)) begin bad++; $display("[TB] FAIL d1_vec c=%0d got=%b", c, {pc, qc, rc}); end
            total++; if (done_c !== (c == 9)) begin bad++; $display("[TB] FAIL d1_done c=%0d got=%b want=%b", c, done_c, (c == 9)); end
            if (c == 9) begin
                total++; if (table_c !== 16'h5500) begin bad++; $display("[TB] FAIL d1_table got=%h want=5500", table_c); end
                total++; if (pass_c !== 1'b1) begin bad++; $display("[TB] FAIL d1_pass got=%b want=1", pass_c); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic exp_busy;
        @(negedge clk);
        start_d = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            exp_busy = !(c == 17 || c == 18 || c >= 35);
            total++; if (busy_d !== exp_busy) begin bad++; $display("[TB] FAIL bb_busy c=%0d got=%b want=%b", c, busy_d, exp_busy); end
            total++; if (done_d !== (c == 17 || c == 35)) begin bad++; $display("[TB] FAIL bb_done c=%0d got=%b want=%b", c, done_d, (c == 17 || c == 35)); end
            if (c == 17 || c == 35) begin
                total++; if (table_d !== 16'hD8D8) begin bad++; $display("[TB] FAIL bb_table c=%0d got=%h want=d8d8", c, table_d); end
                total++; if (pass_d !== 1'b0) begin bad++; $display("[TB] FAIL bb_pass c=%0d got=%b want=0", c, pass_d); end
            end
        end
        start_d = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_adder();
        test_restart_ignored();
        test_mid_reset();
        test_dwell_one();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
